loop_stack: RTL

Loop-nesting stack for the control unit. It accepts decoded loop-start and loop-end instructions, maintains up to 8 nested loop descriptors with per-level iteration counters, and drives the packed 8×24-bit loop table and top-of-stack address. The downstream loop selector uses these outputs to pick the active loop descriptor.

---
 rtl/loop_stack_if.sv | 19 +
 rtl/loop_stack.sv | 135 +++++++++++++
 2 files changed

// File: rtl/loop_stack_if.sv
// Instruction bus from the loop decoder into loop_stack: one loop-start or
// loop-end per cycle, plus a synchronous flush.
interface loop_stack_if #(
  parameter int ENTRY_W = 24
);
  logic               instr_valid;
  logic               instr_new_loop;
  logic [ENTRY_W-1:0] instr_payload;
  logic               instr_independent;
  logic               flush;

  modport master (
    output instr_valid, instr_new_loop, instr_payload, instr_independent, flush
  );

  modport slave (
    input instr_valid, instr_new_loop, instr_payload, instr_independent, flush
  );
endinterface

// File: rtl/loop_stack.sv
// Loop-nesting stack: up to 8 loop descriptors with per-level iteration
// counters. Define LOOP_STACK_ERR_EN to build the sticky overflow/underflow flags.
module loop_stack #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  loop_stack_if.slave                bus,
  output logic [0:DEPTH*ENTRY_W-1]   loop_table,
  output logic [DEPTH-1:0]           independent_mask,
  output logic [3:0]                 depth,
  output logic [2:0]                 top_addr,
  output logic [15:0]                cur_iter,
  output logic                       loop_again,
  output logic                       loop_done,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int CNT_W = 16;

  logic [ENTRY_W-1:0] desc_q [DEPTH];
  logic [CNT_W-1:0]   cnt_q  [DEPTH];
  logic [DEPTH-1:0]   ind_q;
  logic [3:0]         depth_q;
  logic               again_q;
  logic               done_q;

  logic             full;
  logic             empty;
  logic [2:0]       top_idx;
  logic [2:0]       push_idx;
  logic [CNT_W-1:0] top_trip;
  logic [CNT_W:0]   trip_eff;
  logic [CNT_W:0]   next_cnt;
  logic             pop;
  logic             accept;
  logic             do_push;
  logic             do_end;

  always_comb begin
    full     = (depth_q == 4'(DEPTH));
    empty    = (depth_q == 4'd0);
    top_idx  = empty ? 3'd0 : 3'(depth_q - 4'd1);
    push_idx = depth_q[2:0];
    top_trip = desc_q[top_idx][ENTRY_W-1 -: CNT_W];
    // Trip count 0 behaves as 1; 17-bit compare so a 0xFFFF counter cannot wrap.
    trip_eff = (top_trip == '0) ? 17'd1 : {1'b0, top_trip};
    next_cnt = {1'b0, cnt_q[top_idx]} + 17'd1;
    pop      = (next_cnt >= trip_eff);
    accept   = bus.instr_valid & ~bus.flush;
    do_push  = accept &  bus.instr_new_loop & ~full;
    do_end   = accept & ~bus.instr_new_loop & ~empty;
  end

  // NOTE: the descriptor/counter arrays are reset and cleared element by element
  // because entries above the top must always read 0; this rules out RAM inference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        desc_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ind_q   <= '0;
      depth_q <= '0;
      again_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      again_q <= do_end & ~pop;
      done_q  <= do_end &  pop;
      if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          desc_q[i] <= '0;
          cnt_q[i]  <= '0;
        end
        ind_q   <= '0;
        depth_q <= '0;
      end else if (do_push) begin
        desc_q[push_idx] <= bus.instr_payload;
        cnt_q[push_idx]  <= '0;
        ind_q[push_idx]  <= bus.instr_independent;
        depth_q          <= depth_q + 4'd1;
      end else if (do_end) begin
        if (pop) begin
          desc_q[top_idx] <= '0;
          cnt_q[top_idx]  <= '0;
          ind_q[top_idx]  <= 1'b0;
          depth_q         <= depth_q - 4'd1;
        end else begin
          cnt_q[top_idx] <= next_cnt[CNT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    loop_table = '0;
    for (int i = 0; i < DEPTH; i++) begin
      loop_table[i*ENTRY_W +: ENTRY_W] = desc_q[i];
    end
  end

  assign independent_mask = ind_q;
  assign depth            = depth_q;
  assign top_addr         = top_idx;
  assign cur_iter         = empty ? '0 : cnt_q[top_idx];
  assign loop_again       = again_q;
  assign loop_done        = done_q;

`ifdef LOOP_STACK_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (accept &  bus.instr_new_loop & full)  ovf_q <= 1'b1;
      if (accept & ~bus.instr_new_loop & empty) unf_q <= 1'b1;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule
